serial_adder_w: RTL and testbench

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's 1-bit full adder. It adds two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a single registered DIGIT-bit full-adder slice. It sits behind a start/busy/done handshake so a controller can issue operations without extra glue. It also reports carry-out and signed overflow, and supports a subtract mode.

---
 rtl/serial_adder_w.sv | 140 ++++++++++++++
 tb/tb_serial_adder_w.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_w.sv
// serial_adder_w: multi-cycle adder/subtractor. WIDTH-bit operands are summed
// DIGIT bits per clock through one registered DIGIT-bit full-adder slice,
// LSB slice first, taking N = WIDTH/DIGIT cycles per operation.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  operation request, sampled only while busy=0
//   sub    0: a+b+ci, 1: a-b (a+~b+1, ci ignored); latched with start
//   a, b   operands, latched with start
//   ci     carry-in, latched with start
//   busy   operation in progress
//   done   one-cycle completion pulse
//   s      result, updated only at completion
//   co     final carry-out (in sub mode 1 means no borrow)
//   ovf    two's-complement overflow
module serial_adder_w #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   slice_sum;
  logic             c_into_msb;

  always_comb begin
    slice_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + (DIGIT+1)'(carry_q);
    // Carry into the slice's top bit recovered from its sum bit; on the
    // final slice this is the carry into the word MSB.
    c_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_sum[DIGIT];
        // New slice enters at the top; after N slices the LSB slice has
        // been shifted down to bit 0.
        res_d   = (res_q >> DIGIT)
                | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          s_d     = res_d;
          co_d    = slice_sum[DIGIT];
          ovf_d   = c_into_msb ^ slice_sum[DIGIT];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_w.sv
// Directed bench for serial_adder_w. Five instances: W8/D1, W8/D4,
// W4/D1, W4/D2, W4/D4 share reset and operand buses, each has its own start.
module tb_serial_adder_w;

  logic       clk;
  logic       rst_n;
  logic [4:0] start_v;
  logic       sub;
  logic       ci;
  logic [7:0] a;
  logic [7:0] b;

  logic       bz0, bz1, bz2, bz3, bz4;
  logic       dn0, dn1, dn2, dn3, dn4;
  logic       co0, co1, co2, co3, co4;
  logic       ov0, ov1, ov2, ov3, ov4;
  logic [7:0] s0, s1;
  logic [3:0] s2, s3, s4;

  logic [4:0] busy_v, done_v, co_v, ovf_v;
  assign busy_v = {bz4, bz3, bz2, bz1, bz0};
  assign done_v = {dn4, dn3, dn2, dn1, dn0};
  assign co_v   = {co4, co3, co2, co1, co0};
  assign ovf_v  = {ov4, ov3, ov2, ov1, ov0};

  serial_adder_w #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b),
    .ci(ci), .busy(bz0), .done(dn0), .s(s0), .co(co0), .ovf(ov0));
  serial_adder_w #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b),
    .ci(ci), .busy(bz1), .done(dn1), .s(s1), .co(co1), .ovf(ov1));
  serial_adder_w #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a[3:0]),
    .b(b[3:0]), .ci(ci), .busy(bz2), .done(dn2), .s(s2), .co(co2), .ovf(ov2));
  serial_adder_w #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub), .a(a[3:0]),
    .b(b[3:0]), .ci(ci), .busy(bz3), .done(dn3), .s(s3), .co(co3), .ovf(ov3));
  serial_adder_w #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .sub(sub), .a(a[3:0]),
    .b(b[3:0]), .ci(ci), .busy(bz4), .done(dn4), .s(s4), .co(co4), .ovf(ov4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] get_s(input int k);
    case (k)
      0: get_s = s0;
      1: get_s = s1;
      2: get_s = {4'h0, s2};
      3: get_s = {4'h0, s3};
      default: get_s = {4'h0, s4};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic civ, input logic subv,
                        input logic [7:0] es, input logic eco,
                        input logic eovf, input int en, input string tag);
    int lat;
    int bcnt;
    a = av; b = bv; ci = civ; sub = subv;
    start_v[k] = 1'b1;
    @(posedge clk);
    bcnt = 0;
    for (lat = 0; lat < 64; lat++) begin
      @(negedge clk);
      if (lat == 0) start_v[k] = 1'b0;
      if (done_v[k]) break;
      if (busy_v[k]) bcnt++;
    end
    check({tag, "_lat"},  lat, en);
    check({tag, "_busyc"}, bcnt, en);
    check({tag, "_bz"},   {31'b0, busy_v[k]}, 0);
    check({tag, "_s"},    {24'b0, get_s(k)}, {24'b0, es});
    check({tag, "_co"},   {31'b0, co_v[k]}, {31'b0, eco});
    check({tag, "_ovf"},  {31'b0, ovf_v[k]}, {31'b0, eovf});
  endtask

  initial begin
    logic [3:0] bb;
    logic [4:0] tot;
    logic [3:0] es;
    logic       eovf;
    int         dcount;
    logic [7:0] s_at_done;

    rst_n = 1'b0; start_v = '0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy_v[0]}, 0);
    check("rst_done", {31'b0, done_v[0]}, 0);
    check("rst_s",    {24'b0, s0}, 0);
    check("rst_co",   {31'b0, co_v[0]}, 0);
    check("rst_ovf",  {31'b0, ovf_v[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed overflow into the sign bit
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8, "ovf8");
    @(negedge clk);
    check("ovf8_pulse", {31'b0, done_v[0]}, 0);

    // Unsigned wrap, then subtract started in the done cycle
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8, "wrap");
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8, "b2bsub");
    @(negedge clk);

    // Two nibbles per op with carry-in
    run_op(1, 8'h3C, 8'hC4, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 2, "d4");
    @(negedge clk);

    // Start while busy must be ignored
    a = 8'h10; b = 8'h20; ci = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0; a = 8'h77;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; a = 8'h12; b = 8'h34;
    dcount = 0; s_at_done = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (dcount == 0) s_at_done = s0;
        dcount++;
      end
    end
    check("ign_dcount", dcount, 1);
    check("ign_s",      {24'b0, s_at_done}, 32'h30);
    check("ign_hold_s", {24'b0, s0}, 32'h30);

    // Reset mid-operation
    a = 8'h55; b = 8'h55; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'b0, busy_v[0]}, 0);
    check("mrst_done", {31'b0, done_v[0]}, 0);
    check("mrst_s",    {24'b0, s0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) dcount++;
    end
    check("mrst_nodone", dcount, 0);
    run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 8, "post_rst");
    @(negedge clk);

    // Exhaustive 4-bit against a reference model
    for (int k = 2; k <= 4; k++) begin
      for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
          for (int m = 0; m < 4; m++) begin
            bb   = m[1] ? ~bv[3:0] : bv[3:0];
            tot  = {1'b0, av[3:0]} + {1'b0, bb} + (m[1] ? 5'd1 : {4'd0, m[0]});
            es   = tot[3:0];
            eovf = (av[3] == bb[3]) && (es[3] != av[3]);
            run_op(k, {4'h0, av[3:0]}, {4'h0, bv[3:0]}, m[0], m[1],
                   {4'h0, es}, tot[4], eovf, (k == 2) ? 4 : (k == 3) ? 2 : 1,
                   $sformatf("x%0d_%0h_%0h_%0d", k, av, bv, m));
          end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
